// File: rtl/reg_writeback_queue.sv
// Register write-back queue: buffers result-stage writes and drains them in order into the RF write port.
// Latency: a write accepted at edge N is presented on wr_* in cycle N+1 at the earliest; lookups are combinational.
// Backpressure: in_ready = !full with no same-cycle bypass; drain_hold stalls the write port while pushes continue.
// Optional: define WB_COALESCE_EN to merge a push into the newest entry when it targets the same register.
module reg_writeback_queue #(
   parameter int REG_COUNT = 32,
   parameter int REG_W     = 32,
   parameter int REG_IDX_W = $clog2(REG_COUNT),
   parameter int DEPTH     = 4,
   parameter int PTR_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_IDX_W-1:0] in_reg,
   input  logic [REG_W-1:0]     in_data,
   input  logic                 drain_hold,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] wr_reg,
   output logic [REG_W-1:0]     wr_data,
   input  logic [REG_IDX_W-1:0] lookup_reg_a,
   output logic                 lookup_hit_a,
   output logic [REG_W-1:0]     lookup_data_a,
   input  logic [REG_IDX_W-1:0] lookup_reg_b,
   output logic                 lookup_hit_b,
   output logic [REG_W-1:0]     lookup_data_b,
   output logic [PTR_W:0]       count,
   output logic                 empty,
   output logic                 full
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

   logic [REG_IDX_W-1:0] reg_q  [DEPTH];
   logic [REG_W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0]     vld_q, vld_d;
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [PTR_W-1:0]     newest;
   logic                 push_ok, coalesce, alloc, pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign count    = count_q;
   assign in_ready = !full;
   assign newest   = tail_q - PTR_W'(1);

   // Writes to register 0 complete the handshake but are dropped.
   assign push_ok  = in_valid && in_ready && (in_reg != '0);
   assign wr_en    = !empty && !drain_hold;
   assign pop      = wr_en;
   assign wr_reg   = empty ? '0 : reg_q[head_q];
   assign wr_data  = empty ? '0 : data_q[head_q];

`ifdef WB_COALESCE_EN
   // Merge into the newest entry unless it is the sole entry leaving this cycle.
   assign coalesce = push_ok && !empty && (reg_q[newest] == in_reg) &&
                     !(pop && (count_q == ONE_CNT));
`else
   assign coalesce = 1'b0;
`endif
   assign alloc    = push_ok && !coalesce;

   // Next-state for pointers, occupancy and per-entry valid bits.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      if (pop) begin
         head_d         = head_q + PTR_W'(1);
         vld_d[head_q]  = 1'b0;
      end
      if (alloc) begin
         tail_d         = tail_q + PTR_W'(1);
         vld_d[tail_q]  = 1'b1;
      end
      if (alloc && !pop) begin
         count_d = count_q + ONE_CNT;
      end else if (pop && !alloc) begin
         count_d = count_q - ONE_CNT;
      end
   end

   // Control state; reset discards everything queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Entry payload; only meaningful where the valid bit is set, so no reset.
   always_ff @(posedge clk) begin
      if (alloc) begin
         reg_q[tail_q]  <= in_reg;
         data_q[tail_q] <= in_data;
      end
      if (coalesce) begin
         data_q[newest] <= in_data;
      end
   end

   // Forwarding lookups: walk oldest to newest so the newest match wins.
   always_comb begin
      lookup_hit_a  = 1'b0;
      lookup_data_a = '0;
      lookup_hit_b  = 1'b0;
      lookup_data_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[head_q + PTR_W'(i)] && (lookup_reg_a != '0) &&
             (reg_q[head_q + PTR_W'(i)] == lookup_reg_a)) begin
            lookup_hit_a  = 1'b1;
            lookup_data_a = data_q[head_q + PTR_W'(i)];
         end
         if (vld_q[head_q + PTR_W'(i)] && (lookup_reg_b != '0) &&
             (reg_q[head_q + PTR_W'(i)] == lookup_reg_b)) begin
            lookup_hit_b  = 1'b1;
            lookup_data_b = data_q[head_q + PTR_W'(i)];
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vectors, expected writes go to a scoreboard queue.
// A negedge monitor pops and compares every issued register-file write.
// Status outputs are checked directly by the stimulus process one step after each edge.
module tb_reg_writeback_queue;

   localparam int REG_W = 32;
   localparam int IDX_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [IDX_W-1:0]  in_reg;
   logic [REG_W-1:0]  in_data;
   logic              drain_hold;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_reg;
   logic [REG_W-1:0]  wr_data;
   logic [IDX_W-1:0]  lookup_reg_a, lookup_reg_b;
   logic              lookup_hit_a, lookup_hit_b;
   logic [REG_W-1:0]  lookup_data_a, lookup_data_b;
   logic [2:0]        count;
   logic              empty, full;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [IDX_W-1:0] r;
      logic [REG_W-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   reg_writeback_queue dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
      .drain_hold(drain_hold),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .lookup_reg_a(lookup_reg_a), .lookup_hit_a(lookup_hit_a), .lookup_data_a(lookup_data_a),
      .lookup_reg_b(lookup_reg_b), .lookup_hit_b(lookup_hit_b), .lookup_data_b(lookup_data_b),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle offer; records the expected write unless it targets register 0.
   task automatic push(input logic [IDX_W-1:0] r, input logic [REG_W-1:0] d);
      wr_t e;
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      if (r != '0) begin
         e.r = r;
         e.d = d;
         exp_q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Scoreboard monitor: every issued write must match the oldest expected one.
   always @(negedge clk) begin
      wr_t e;
      if (!reset && wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, wr_reg}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_reg", {27'd0, wr_reg}, {27'd0, e.r});
            check("wr_data", wr_data, e.d);
         end
      end
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_hold = 1'b0;
      lookup_reg_a = 5'd5; lookup_reg_b = 5'd0;

      // Reset then idle.
      tick(); tick();
      check("rst_wr_en",    wr_en, 0);
      check("rst_count",    count, 0);
      check("rst_empty",    empty, 1);
      check("rst_full",     full, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_hit_a",    lookup_hit_a, 0);
      reset = 1'b0;
      tick();

      // Single write: visible the cycle after the push, gone the cycle after that.
      push(5'd5, 32'hDEAD_BEEF);
      check("single_wr_en", wr_en, 1);
      check("single_count", count, 1);
      tick();
      check("single_count_after", count, 0);
      check("single_empty_after", empty, 1);

      // Fill under hold, offer a fifth, then drain in order.
      drain_hold = 1'b1;
      for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i);
      check("fill_full",     full, 1);
      check("fill_in_ready", in_ready, 0);
      check("fill_count",    count, 4);
      in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h999;
      tick();
      in_valid = 1'b0;
      check("fifth_rejected_count", count, 4);
      drain_hold = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("drain_empty", empty, 1);

      // Forwarding picks the newest match.
      drain_hold = 1'b1;
      push(5'd7, 32'h11);
      push(5'd3, 32'h22);
      push(5'd7, 32'h33);
      lookup_reg_a = 5'd7; lookup_reg_b = 5'd3;
      #1;
      check("fwd_hit_a",  lookup_hit_a, 1);
      check("fwd_data_a", lookup_data_a, 32'h33);
      check("fwd_hit_b",  lookup_hit_b, 1);
      check("fwd_data_b", lookup_data_b, 32'h22);
      lookup_reg_a = 5'd9; lookup_reg_b = 5'd0;
      #1;
      check("miss_hit_a",  lookup_hit_a, 0);
      check("miss_data_a", lookup_data_a, 0);
      check("zero_hit_b",  lookup_hit_b, 0);
      drain_hold = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("fwd_drain_empty", empty, 1);
      lookup_reg_a = 5'd7;
      #1;
      check("fwd_hit_after_drain", lookup_hit_a, 0);

      // Register 0 handshakes but is not stored.
      in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFF;
      #1;
      check("r0_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("r0_count", count, 0);
      check("r0_wr_en", wr_en, 0);

      // Back-to-back pushes while draining: occupancy holds at one.
      push(5'd1, 32'hA1);
      push(5'd2, 32'hA2);
      check("stream_count", count, 1);
      push(5'd3, 32'hA3);
      check("stream_count2", count, 1);
      tick();
      check("stream_empty", empty, 1);

      // Reset mid-stream discards queued writes.
      drain_hold = 1'b1;
      push(5'd10, 32'hB0);
      push(5'd11, 32'hB1);
      push(5'd12, 32'hB2);
      check("mid_count", count, 3);
      exp_q.delete();
      drain_hold = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_empty", empty, 1);

      // Same-register pair under hold.
      drain_hold = 1'b1;
      push(5'd6, 32'h1);
`ifdef WB_COALESCE_EN
      in_valid = 1'b1; in_reg = 5'd6; in_data = 32'h2;
      exp_q[exp_q.size()-1].d = 32'h2;
      tick();
      in_valid = 1'b0;
      check("coalesce_count", count, 1);
`else
      push(5'd6, 32'h2);
      check("coalesce_count", count, 2);
`endif
      drain_hold = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("final_empty", empty, 1);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
